keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_pkg.sv | 7 +
 rtl/scan_dwell_timer.sv | 19 +
 rtl/keypad_scanner.sv | 126 ++++++++++++
 tb/tb_keypad_scanner.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared FSM state encoding and width helper for the keypad scanner
package keypad_scanner_pkg;
  typedef enum logic [1:0] {DWELL, SAMPLE, UPDATE, NEXT} state_t;
  function automatic int GET_WIDTH(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/scan_dwell_timer.sv
// scan_dwell_timer: row dwell prescaler, o_done pulses while the count sits at DWELL_CNT-1
// Ports: clk, rst_n (sync active-low), i_clr (hold count at zero), o_done (end-of-dwell pulse)
module scan_dwell_timer
  import keypad_scanner_pkg::*;
#(
  parameter int DWELL_CNT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_done
);
  localparam int W = GET_WIDTH(DWELL_CNT - 1);
  logic [W-1:0] r_cnt;
  assign o_done = r_cnt == W'(DWELL_CNT - 1);
  always_ff @(posedge clk)
    if (!rst_n || i_clr || o_done) r_cnt <= '0;
    else r_cnt <= r_cnt + W'(1);
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: active-low matrix scanner with per-key scan debounce and key-code event handshake
// Ports: clk, rst_n (sync active-low); row_o active-low row drive; col_i active-low column sense;
//   key_state debounced states (bit r*COLS+c); key_code/key_valid/key_ack event handshake;
//   key_release (only with KEYPAD_RELEASE_EVT_EN defined) marks release events.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_FREQ       = 100,
  parameter int SCAN_US        = 1000,
  parameter int DEBOUNCE_SCANS = 10,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  localparam int N             = ROWS * COLS,
  localparam int KW            = GET_WIDTH(N - 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_o,
  input  logic [COLS-1:0] col_i,
  output logic [N-1:0]    key_state,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
`ifdef KEYPAD_RELEASE_EVT_EN
  output logic            key_release,
`endif
  input  logic            key_ack
);
  localparam int DWELL_CNT = CLK_FREQ * SCAN_US;
  localparam int CW = GET_WIDTH(DEBOUNCE_SCANS - 1);
  localparam int RW = GET_WIDTH(ROWS - 1);
  localparam int LW = GET_WIDTH(COLS - 1);
  state_t          r_fsm;
  logic [COLS-1:0] r_col_s1, r_col_s2, r_samp;
  logic [RW-1:0]   r_row;
  logic [LW-1:0]   r_col;
  logic [ROWS-1:0] r_row_o;
  logic [N-1:0]    r_state;
  logic [CW-1:0]   r_cnt [N];
  logic [KW-1:0]   r_code;
  logic            r_valid;
  logic            w_done, w_diff, w_flip, w_evt, w_stall, w_last;
  logic [KW-1:0]   w_k;
  logic [RW-1:0]   w_row_nx;
  assign row_o     = r_row_o;
  assign key_state = r_state;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign w_k      = KW'(int'(r_row) * COLS + int'(r_col));
  assign w_diff   = r_samp[r_col] != r_state[w_k];
  assign w_flip   = w_diff && r_cnt[w_k] == CW'(DEBOUNCE_SCANS - 1);
`ifdef KEYPAD_RELEASE_EVT_EN
  logic r_rel;
  assign key_release = r_rel;
  assign w_evt = w_flip;
`else
  assign w_evt = w_flip && !r_state[w_k];
`endif
  // A new event cannot overwrite an unaccepted one, so the column walk waits instead.
  assign w_stall  = w_evt && r_valid && !key_ack;
  assign w_last   = r_col == LW'(COLS - 1);
  assign w_row_nx = r_row == RW'(ROWS - 1) ? '0 : r_row + RW'(1);
  scan_dwell_timer #(.DWELL_CNT(DWELL_CNT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_fsm != DWELL),
    .o_done(w_done)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_col_s1 <= '1;
      r_col_s2 <= '1;
    end else begin
      r_col_s1 <= col_i;
      r_col_s2 <= r_col_s1;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_fsm   <= DWELL;
      r_row   <= '0;
      r_col   <= '0;
      r_row_o <= '1;
      r_samp  <= '0;
      r_state <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
      r_rel   <= 1'b0;
`endif
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      if (r_valid && key_ack) r_valid <= 1'b0;
      case (r_fsm)
        DWELL: begin
          r_row_o <= ~(ROWS'(1) << r_row);
          if (w_done) r_fsm <= SAMPLE;
        end
        SAMPLE: begin
          r_samp <= ~r_col_s2;
          r_col  <= '0;
          r_fsm  <= UPDATE;
        end
        UPDATE:
          if (!w_stall) begin
            r_cnt[w_k] <= (w_diff && !w_flip) ? r_cnt[w_k] + CW'(1) : '0;
            if (w_flip) r_state[w_k] <= ~r_state[w_k];
            if (w_evt) begin
              r_valid <= 1'b1;
              r_code  <= w_k;
`ifdef KEYPAD_RELEASE_EVT_EN
              r_rel   <= r_state[w_k];
`endif
            end
            r_col <= r_col + LW'(1);
            // The next row is driven already while NEXT runs.
            if (w_last) begin
              r_fsm   <= NEXT;
              r_row_o <= ~(ROWS'(1) << w_row_nx);
            end
          end
        default: begin
          r_row <= w_row_nx;
          r_fsm <= DWELL;
        end
      endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized scoreboard bench for keypad_scanner against a per-visit debounce model
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_ack = 1'b0;
  logic [3:0]  row_o, col_i, key_code;
  logic [15:0] key_state;
  logic        key_valid;
  logic [15:0] press = '0;
  logic [15:0] next_press = '0;
  int errors = 0, checks = 0, visits = 0, cyc = 0, ack_mode = 1;
  int vrow[4] = '{0, 0, 0, 0};
  int exp_q[$];
  int log_code[$];
  int log_cyc[$];
`ifdef KEYPAD_RELEASE_EVT_EN
  logic key_release;
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  keypad_scanner #(.CLK_FREQ(1), .SCAN_US(4), .DEBOUNCE_SCANS(3), .ROWS(4), .COLS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_o    (row_o),
    .col_i    (col_i),
    .key_state(key_state),
    .key_code (key_code),
    .key_valid(key_valid),
`ifdef KEYPAD_RELEASE_EVT_EN
    .key_release(key_release),
`endif
    .key_ack  (key_ack)
  );
  always #5 clk = ~clk;
  always_comb begin
    col_i = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !row_o[r]) col_i[c] = 1'b0;
  end
  always @(posedge clk) begin
    #1;
    key_ack = ack_mode == 0 ? 1'b0 : ack_mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
  end
  // Reference model: each row visit is one scan of that row; a key flips after 3 disagreeing visits.
  logic [15:0] st = '0;
  int cnt[16];
  logic [3:0] prev_row = '1;
  always @(negedge clk) begin
    if (!rst_n) begin
      st = '0;
      foreach (cnt[i]) cnt[i] = 0;
      exp_q.delete();
      prev_row = '1;
    end else if (row_o != prev_row) begin
      if (row_o != 4'hf) begin
        int r, er;
        r = -1;
        for (int i = 0; i < 4; i++) if (!row_o[i]) r = i;
        er = 0;
        for (int i = 0; i < 4; i++) if (!prev_row[i]) er = (i + 1) % 4;
        checks++;
        if (row_o !== ~(4'b1 << er)) begin
          errors++;
          $display("FAIL row_seq: row_o=%b expected %b", row_o, ~(4'b1 << er));
        end
        checks++;
        if (key_state !== st) begin
          errors++;
          $display("FAIL key_state: got %h expected %h", key_state, st);
        end
        press = next_press;
        if (r >= 0) begin
          for (int c = 0; c < 4; c++) begin
            int k;
            k = r * 4 + c;
            if (press[k] == st[k]) cnt[k] = 0;
            else if (++cnt[k] == 3) begin
              cnt[k] = 0;
              st[k] = press[k];
              if (press[k] || REL) exp_q.push_back(k);
            end
          end
          vrow[r]++;
        end
        visits++;
      end
      prev_row = row_o;
    end
  end
  logic       pv = 1'b0, pa = 1'b0;
  logic [3:0] pc = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pv = 1'b0;
      pa = 1'b0;
    end else begin
      if (key_valid && (!pv || pa)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event: unexpected key_code=%0d", key_code);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (key_code !== 4'(e)) begin
            errors++;
            $display("FAIL event: key_code=%0d expected %0d", key_code, e);
          end
        end
        log_code.push_back(int'(key_code));
        log_cyc.push_back(cyc);
      end else if (key_valid && pv && !pa) begin
        checks++;
        if (key_code !== pc) begin
          errors++;
          $display("FAIL hold: key_code=%0d changed from %0d while unacknowledged", key_code, pc);
        end
      end
      pv = key_valid;
      pa = key_ack;
      pc = key_code;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_visits(input int n);
    int v0, t;
    v0 = visits;
    t = 0;
    while (visits < v0 + n && t < 100 * n + 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("wait_visits_timeout", 32'(visits >= v0 + n), 1);
  endtask
  task automatic wait_row(input int r, input int n);
    int v0, t;
    v0 = vrow[r];
    t = 0;
    while (vrow[r] < v0 + n && t < 400 * n + 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("wait_row_timeout", 32'(vrow[r] >= v0 + n), 1);
  endtask
  task automatic wait_valid(input logic [3:0] code);
    int t;
    t = 0;
    while (!(key_valid && key_code == code) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_valid_timeout", 32'(key_valid && key_code == code), 1);
  endtask
  initial begin
    int t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row_o", 32'(row_o), 32'hf);
    chk("rst_key_state", 32'(key_state), 0);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_code", 32'(key_code), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_visits(2);
    t0 = cyc;
    wait_visits(1);
    chk("visit_len", 32'(cyc - t0), 10);
    wait_visits(5);
    next_press[9] = 1'b1;
    wait_row(2, 3);
    wait_visits(1);
    chk("press_9", 32'(key_state[9]), 1);
    wait_row(2, 3);
    chk("single_event", 32'(exp_q.size()), 0);
    next_press = '0;
    wait_row(2, 4);
    next_press[0] = 1'b1;
    wait_row(0, 2);
    next_press[0] = 1'b0;
    wait_row(0, 3);
    chk("glitch_0", 32'(key_state[0]), 0);
    ack_mode = 0;
    next_press = 16'h0090;
    wait_valid(4'd4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_row_o", 32'(row_o), 32'b1101);
    chk("stall_valid", 32'(key_valid), 1);
    chk("stall_code", 32'(key_code), 4);
    ack_mode = 1;
    for (int i = 0; i < 5 && !key_ack; i++) @(negedge clk);
    chk("ack_code", 32'(key_code), 4);
    @(negedge clk);
    chk("b2b_valid", 32'(key_valid), 1);
    chk("b2b_code", 32'(key_code), 7);
    next_press = '0;
    wait_row(1, 4);
    log_code.delete();
    log_cyc.delete();
    next_press = 16'hb000;
    wait_row(3, 4);
    chk("row3_n", 32'(log_code.size()), 3);
    chk("row3_c0", 32'(log_code[0]), 12);
    chk("row3_c1", 32'(log_code[1]), 13);
    chk("row3_c2", 32'(log_code[2]), 15);
    chk("row3_gap", 32'(log_cyc[1] - log_cyc[0]), 1);
    next_press = '0;
    wait_row(3, 4);
    ack_mode = 2;
    repeat (40) begin
      next_press = 16'($urandom);
      wait_visits(int'($urandom_range(1, 6)));
    end
    next_press = '0;
    ack_mode = 1;
    wait_visits(16);
    ack_mode = 0;
    next_press[9] = 1'b1;
    wait_valid(4'd9);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", 32'(key_valid), 0);
    chk("rst_mid_state", 32'(key_state), 0);
    chk("rst_mid_row_o", 32'(row_o), 32'hf);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ack_mode = 1;
    wait_row(2, 2);
    wait_visits(1);
    chk("redebounce_early", 32'(key_state[9]), 0);
    wait_row(2, 1);
    wait_visits(1);
    chk("redebounce_9", 32'(key_state[9]), 1);
    next_press = '0;
    wait_visits(16);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
